// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard scheduler of the 5-stage MIPS core.
//   state_t      : scheduler FSM states (RUN, MUL_WAIT)
//   PCSRC_*      : PCSrc encodings produced by ID decode for j/jal and jr
//   OP_MUL/FN_MUL: opcode/funct of `mul`, used by the decoder driving ex_is_mul
//   REG_ZERO     : hard-wired zero register, never a load-use source
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] PCSRC_J  = 2'b01;
    localparam logic [1:0] PCSRC_JR = 2'b10;

    localparam logic [5:0] OP_MUL = 6'h1c;
    localparam logic [5:0] FN_MUL = 6'h02;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_loaduse_cmp.sv
// -----------------------------------------------------------------------------
// hazard_loaduse_cmp
// Purely combinational load-use detector: flags when the lw currently in EX
// writes a register that the instruction in ID reads.
// Ports:
//   id_rs, id_rt         in  source register fields of the ID instruction
//   id_uses_rs/rt        in  ID instruction actually reads rs/rt
//   ex_mem_read          in  EX instruction is a load
//   ex_rt                in  destination of the load in EX
//   hazard               out load-use hazard present
// -----------------------------------------------------------------------------
module hazard_loaduse_cmp
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       hazard
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs && (id_rs == ex_rt);
    assign rt_hit = id_uses_rt && (id_rt == ex_rt);

    // $0 is hard-wired to zero, so a load targeting it never produces data.
    assign hazard = ex_mem_read && (ex_rt != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_sched.sv
// -----------------------------------------------------------------------------
// hazard_sched
// Pipeline hazard scheduler for the 5-stage MIPS core. Sits beside ID and
// drives the PC / IF/ID / ID/EX enables and flushes to resolve load-use
// stalls, jump/branch flushes and multi-cycle mul occupancy of the EX ALU.
//
// Optional feature macro: HAZARD_STALL_CNT_EN
//   defined   -> stall_cnt port counts cycles with pc_write==0 (saturating)
//   undefined -> no stall_cnt port or register
//
// Parameters:
//   MUL_LATENCY  total EX cycles taken by mul (1..15)
//   CNT_W        width of stall_cnt
// Ports:
//   clk, reset (async, active-low)
//   id_rs, id_rt, id_uses_rs, id_uses_rt, id_pcsrc   ID decode fields
//   ex_mem_read, ex_rt, ex_is_mul, ex_branch_taken   EX status
//   pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush  pipeline ctl
//   mul_busy                                          FSM in MUL_WAIT
//   stall_cnt                                         only with the macro
// -----------------------------------------------------------------------------
module hazard_sched
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [1:0] id_pcsrc,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_is_mul,
    input  logic       ex_branch_taken,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_write,
    output logic       id_ex_flush,
    output logic       mul_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam int MC_W       = $clog2(MUL_LATENCY + 1);
    localparam int MUL_LOAD_I = (MUL_LATENCY >= 2) ? (MUL_LATENCY - 2) : 0;
    localparam logic [MC_W-1:0] MUL_LOAD = MUL_LOAD_I[MC_W-1:0];

    state_t          state_q,    state_d;
    logic [MC_W-1:0] mul_cnt_q,  mul_cnt_d;
    logic            mul_done_q, mul_done_d;

    logic lu_hazard;
    logic mul_start;

    hazard_loaduse_cmp u_cmp (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .hazard      (lu_hazard)
    );

    // A single-cycle mul needs no freeze. mul_done masks the same mul for the
    // one RUN cycle that follows its freeze, while it is still visible in EX.
    assign mul_start = ex_is_mul && !mul_done_q && (MUL_LATENCY > 1);

    always_comb begin
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        mul_done_d  = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        id_ex_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        mul_busy    = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mul_start) begin
                    // First freeze cycle happens here in RUN; load-use and
                    // jump are suppressed, branch cannot coexist with mul.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_write = 1'b0;
                    if (MUL_LATENCY > 2) begin
                        state_d   = MUL_WAIT;
                        mul_cnt_d = MUL_LOAD;
                    end else begin
                        // Latency 2: the RUN cycle alone is the whole freeze.
                        mul_done_d = 1'b1;
                    end
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (lu_hazard) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (id_pcsrc != 2'b00) begin
                    if_id_flush = 1'b1;
                end
            end
            MUL_WAIT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_write = 1'b0;
                mul_busy    = 1'b1;
                mul_cnt_d   = mul_cnt_q - MC_W'(1);
                // The counter is loaded with LATENCY-2 and MUL_WAIT lasts
                // that many cycles; leave as the count reaches zero so the
                // whole freeze (RUN cycle + MUL_WAIT) is LATENCY-1 cycles.
                if (mul_cnt_q <= MC_W'(1)) begin
                    state_d    = RUN;
                    mul_cnt_d  = '0;
                    mul_done_d = 1'b1;
                end
            end
            default: begin
                state_d   = RUN;
                mul_cnt_d = '0;
            end
        endcase

        // Asynchronous reset also forces the outputs, even while EX still
        // shows a mul or a hazard.
        if (!reset) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            id_ex_write = 1'b1;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            mul_busy    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            mul_cnt_q  <= '0;
            mul_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mul_cnt_q  <= mul_cnt_d;
            mul_done_q <= mul_done_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// -----------------------------------------------------------------------------
// tb_hazard_sched
// Directed vectors for hazard_sched (MUL_LATENCY=4). The driver applies one
// vector per cycle and queues its hand-computed control word; the monitor
// pops and compares on the falling edge.
// Control word bit order: {pc_write, if_id_write, if_id_flush,
//                          id_ex_write, id_ex_flush, mul_busy}
// -----------------------------------------------------------------------------
module tb_hazard_sched;

    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt;
    logic [1:0] id_pcsrc;
    logic       ex_mem_read, ex_is_mul, ex_branch_taken;
    logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, mul_busy;
`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    hazard_sched #(
        .MUL_LATENCY (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_pcsrc        (id_pcsrc),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_is_mul       (ex_is_mul),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_write     (id_ex_write),
        .id_ex_flush     (id_ex_flush),
        .mul_busy        (mul_busy)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic [5:0] ctl;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    // Monitor: the DUT presents a control word every cycle; compare whenever
    // an expectation is pending.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [5:0] act;
            e   = exp_q.pop_front();
            act = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, mul_busy};
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl got %b want %b", e.name, act, e.ctl);
            end else begin
                $display("ok   %s ctl %b", e.name, act);
            end
`ifdef HAZARD_STALL_CNT_EN
            checks++;
            if (stall_cnt !== CNT_W'(e.cnt)) begin
                errors++;
                $display("FAIL %s stall_cnt got %0d want %0d", e.name, stall_cnt, e.cnt);
            end
`endif
        end
    end

    task automatic drive(input string nm,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt,
                         input logic [1:0] pcsrc, input logic mr,
                         input logic [4:0] ert, input logic mul,
                         input logic br, input logic rn,
                         input logic [5:0] exp_ctl);
        exp_t e;
        @(posedge clk);
        #1;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rs      = urs;
        id_uses_rt      = urt;
        id_pcsrc        = pcsrc;
        ex_mem_read     = mr;
        ex_rt           = ert;
        ex_is_mul       = mul;
        ex_branch_taken = br;
        reset           = rn;
        if (!rn) exp_cnt = 0;
        e.name = nm;
        e.ctl  = exp_ctl;
        e.cnt  = exp_cnt;
        exp_q.push_back(e);
        // stall_cnt registers this cycle's stall at the next edge
        if (rn && !exp_ctl[5]) exp_cnt++;
    endtask

    initial begin
        reset = 1'b0;
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_pcsrc = 2'b00;
        ex_mem_read = 1'b0; ex_is_mul = 1'b0; ex_branch_taken = 1'b0;

        //      name             rs  rt  urs urt pcsrc mr ert mul br rn  expected
        drive("reset_with_mul", 5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 1, 0, 0, 6'b110100);
        drive("idle",           5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 0, 0, 1, 6'b110100);
        drive("loaduse_rs8",    5'd8, 5'd1, 1, 0, 2'b00, 1, 5'd8, 0, 0, 1, 6'b000110);
        drive("loaduse_clear",  5'd8, 5'd1, 1, 0, 2'b00, 0, 5'd8, 0, 0, 1, 6'b110100);
        drive("loaduse_rt5",    5'd3, 5'd5, 0, 1, 2'b00, 1, 5'd5, 0, 0, 1, 6'b000110);
        drive("rt_not_used",    5'd3, 5'd5, 0, 0, 2'b00, 1, 5'd5, 0, 0, 1, 6'b110100);
        drive("zero_reg_guard", 5'd0, 5'd0, 1, 1, 2'b00, 1, 5'd0, 0, 0, 1, 6'b110100);
        drive("branch_prio",    5'd8, 5'd0, 1, 0, 2'b01, 1, 5'd8, 0, 1, 1, 6'b111110);
        drive("jr_flush",       5'd2, 5'd0, 1, 0, 2'b10, 0, 5'd0, 0, 0, 1, 6'b111100);
        drive("jr_one_cycle",   5'd2, 5'd0, 1, 0, 2'b00, 0, 5'd0, 0, 0, 1, 6'b110100);
        drive("mul_run_freeze", 5'd8, 5'd0, 1, 0, 2'b01, 1, 5'd8, 1, 0, 1, 6'b000000);
        drive("mul_wait_1",     5'd8, 5'd0, 1, 0, 2'b01, 1, 5'd8, 1, 1, 1, 6'b000001);
        drive("mul_wait_2",     5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 1, 0, 1, 6'b000001);
        drive("mul_no_retrig",  5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 1, 0, 1, 6'b110100);
        drive("after_mul",      5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 0, 0, 1, 6'b110100);
        drive("mul2_run",       5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 1, 0, 1, 6'b000000);
        drive("mul2_wait_1",    5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 1, 0, 1, 6'b000001);
        drive("reset_mid_mul",  5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 1, 0, 0, 6'b110100);
        drive("post_reset_run", 5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 0, 0, 1, 6'b110100);
        drive("post_reset_2",   5'd4, 5'd0, 1, 0, 2'b00, 1, 5'd4, 0, 0, 1, 6'b000110);

        // Bounded wait for the monitor to drain the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
